// File: rtl/bias_act_pipe_pkg.sv
// Shared definitions for the bias/activation/requantisation pipeline.
package bias_act_pipe_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_RELU   = 2'd1,
        MODE_LEAKY  = 2'd2
    } act_mode_e;

    localparam int MODE_W  = 2;
    localparam int SHIFT_W = 5;

endpackage

// File: rtl/bias_act_lane.sv
// One lane of datapath: saturating bias add (stage 1 side) and
// activation + rounding right shift + output saturation (stage 2 side).
// Purely combinational; the top level owns all state.
module bias_act_lane
    import bias_act_pipe_pkg::*;
#(
    parameter int IN_WIDTH   = 32,
    parameter int OUT_WIDTH  = 8,
    parameter int LEAK_SHIFT = 3
) (
    input  logic [IN_WIDTH-1:0]  acc_i,
    input  logic [IN_WIDTH-1:0]  bias_i,
    output logic [IN_WIDTH-1:0]  sum_o,
    input  logic [IN_WIDTH-1:0]  sum_i,
    input  logic [MODE_W-1:0]    mode_i,
    input  logic [SHIFT_W-1:0]   shift_i,
    output logic [OUT_WIDTH-1:0] out_o
);

    logic signed [IN_WIDTH:0]   addExt;
    logic signed [IN_WIDTH-1:0] sumS;
    logic signed [IN_WIDTH-1:0] actVal;
    logic signed [IN_WIDTH:0]   actExt;
    logic signed [IN_WIDTH:0]   roundBias;
    logic signed [IN_WIDTH:0]   rounded;
    logic signed [IN_WIDTH:0]   shifted;
    logic                       fits;

    // Add one guard bit so overflow shows up as a disagreement of the top two bits, then clamp.
    always_comb begin
        addExt = {acc_i[IN_WIDTH-1], acc_i} + {bias_i[IN_WIDTH-1], bias_i};
        if (addExt[IN_WIDTH] != addExt[IN_WIDTH-1]) begin
            sum_o = addExt[IN_WIDTH] ? {1'b1, {(IN_WIDTH-1){1'b0}}}
                                     : {1'b0, {(IN_WIDTH-1){1'b1}}};
        end else begin
            sum_o = addExt[IN_WIDTH-1:0];
        end
    end

    // Activation, then add half an LSB of the result and arithmetic-shift (round half up), then clamp to the output range.
    always_comb begin
        sumS   = sum_i;
        actVal = sumS;
        case (mode_i)
            MODE_RELU:  if (sumS[IN_WIDTH-1]) actVal = '0;
            MODE_LEAKY: if (sumS[IN_WIDTH-1]) actVal = sumS >>> LEAK_SHIFT;
            default:    actVal = sumS;
        endcase
        actExt    = {actVal[IN_WIDTH-1], actVal};
        roundBias = '0;
        if (shift_i != '0) begin
            roundBias = (IN_WIDTH+1)'(1) << (shift_i - SHIFT_W'(1));
        end
        rounded = actExt + roundBias;
        shifted = rounded >>> shift_i;
        fits    = (&shifted[IN_WIDTH:OUT_WIDTH-1]) | ~(|shifted[IN_WIDTH:OUT_WIDTH-1]);
        if (fits) begin
            out_o = shifted[OUT_WIDTH-1:0];
        end else if (shifted[IN_WIDTH]) begin
            out_o = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end else begin
            out_o = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
    end

endmodule

// File: rtl/bias_act_pipe.sv
// Two-stage stallable pipe: stage 1 registers biased sums plus the captured
// config, stage 2 registers the requantised output vector. Both handshakes
// are valid/ready; in_ready depends only on registered state and out_ready.
module bias_act_pipe
    import bias_act_pipe_pkg::*;
#(
    parameter int ARRAY_N    = 16,
    parameter int IN_WIDTH   = 32,
    parameter int OUT_WIDTH  = 8,
    parameter int LEAK_SHIFT = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         bias_wr_en,
    input  logic [$clog2(ARRAY_N)-1:0]   bias_wr_index,
    input  logic [IN_WIDTH-1:0]          bias_wr_data,
    input  logic [MODE_W-1:0]            cfg_mode,
    input  logic [SHIFT_W-1:0]           cfg_shift,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ARRAY_N*IN_WIDTH-1:0]  in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ARRAY_N*OUT_WIDTH-1:0] out_data,
    output logic                         busy,
    output logic [31:0]                  beat_count
);

    logic [ARRAY_N-1:0][IN_WIDTH-1:0] bias_q;
    logic [ARRAY_N*IN_WIDTH-1:0]      sumNext;
    logic [ARRAY_N*IN_WIDTH-1:0]      s1Sum_q;
    logic [MODE_W-1:0]                s1Mode_q;
    logic [SHIFT_W-1:0]               s1Shift_q;
    logic                             s1Valid_q;
    logic                             s1Valid_d;
    logic [ARRAY_N*OUT_WIDTH-1:0]     laneOut;
    logic [ARRAY_N*OUT_WIDTH-1:0]     s2Data_q;
    logic                             s2Valid_q;
    logic                             s2Valid_d;
    logic [31:0]                      beatCount_q;
    logic [31:0]                      beatCount_d;
    logic                             s2Open;
    logic                             inAccept;
    logic                             outFire;

    assign s2Open    = !s2Valid_q || out_ready;
    assign in_ready  = !s1Valid_q || s2Open;
    assign inAccept  = in_valid && in_ready;
    assign outFire   = s2Valid_q && out_ready;
    assign out_valid = s2Valid_q;
    assign out_data  = s2Data_q;
    assign busy      = s1Valid_q || s2Valid_q;
    assign beat_count = beatCount_q;

    for (genvar i = 0; i < ARRAY_N; i++) begin : gLane
        bias_act_lane #(
            .IN_WIDTH  (IN_WIDTH),
            .OUT_WIDTH (OUT_WIDTH),
            .LEAK_SHIFT(LEAK_SHIFT)
        ) uLane (
            .acc_i  (in_data[i*IN_WIDTH +: IN_WIDTH]),
            .bias_i (bias_q[i]),
            .sum_o  (sumNext[i*IN_WIDTH +: IN_WIDTH]),
            .sum_i  (s1Sum_q[i*IN_WIDTH +: IN_WIDTH]),
            .mode_i (s1Mode_q),
            .shift_i(s1Shift_q),
            .out_o  (laneOut[i*OUT_WIDTH +: OUT_WIDTH])
        );
    end

    // Each stage refills whenever it may advance; stage 2 empties only when downstream takes the beat.
    always_comb begin
        s1Valid_d   = s1Valid_q;
        s2Valid_d   = s2Valid_q;
        beatCount_d = beatCount_q;
        if (in_ready) begin
            s1Valid_d = in_valid;
        end
        if (s2Open) begin
            s2Valid_d = s1Valid_q;
        end
        if (outFire) begin
            beatCount_d = beatCount_q + 32'd1;
        end
    end

    // Pipeline registers and bias table; bias reads in stage 1 see the value from before a same-edge write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bias_q      <= '0;
            s1Sum_q     <= '0;
            s1Mode_q    <= '0;
            s1Shift_q   <= '0;
            s1Valid_q   <= 1'b0;
            s2Data_q    <= '0;
            s2Valid_q   <= 1'b0;
            beatCount_q <= '0;
        end else begin
            s1Valid_q   <= s1Valid_d;
            s2Valid_q   <= s2Valid_d;
            beatCount_q <= beatCount_d;
            if (inAccept) begin
                s1Sum_q   <= sumNext;
                s1Mode_q  <= cfg_mode;
                s1Shift_q <= cfg_shift;
            end
            if (s2Open && s1Valid_q) begin
                s2Data_q <= laneOut;
            end
            if (bias_wr_en) begin
                bias_q[bias_wr_index] <= bias_wr_data;
            end
        end
    end

endmodule

// File: tb/tb_bias_act_pipe.sv
// Scoreboard bench for bias_act_pipe with a 4-lane, 32-bit in / 8-bit out configuration.
module tb_bias_act_pipe;

    localparam int N    = 4;
    localparam int IW   = 32;
    localparam int OW   = 8;
    localparam int LS   = 3;
    localparam int IDXW = $clog2(N);
    localparam longint MAX_ACC = 64'sd2147483647;
    localparam longint MIN_ACC = -64'sd2147483648;

    typedef struct {
        logic [N*OW-1:0] data;
        int              cyc;
    } entry_t;

    logic            clk = 1'b0;
    logic            rstN = 1'b1;
    logic            biasWrEn = 1'b0;
    logic [IDXW-1:0] biasWrIndex = '0;
    logic [IW-1:0]   biasWrData = '0;
    logic [1:0]      cfgMode = '0;
    logic [4:0]      cfgShift = '0;
    logic            inValid = 1'b0;
    logic            inReady;
    logic [N*IW-1:0] inData = '0;
    logic            outValid;
    logic            outReady = 1'b1;
    logic [N*OW-1:0] outData;
    logic            busy;
    logic [31:0]     beatCount;

    entry_t sbQ[$];
    int     modelBias[N];
    int     assertCount = 0;
    int     failCount = 0;
    int     cycleCount = 0;
    int     beatModel = 0;
    bit     latencyCheck = 1'b0;
    bit     inReadySample = 1'b1;

    bias_act_pipe #(
        .ARRAY_N   (N),
        .IN_WIDTH  (IW),
        .OUT_WIDTH (OW),
        .LEAK_SHIFT(LS)
    ) dut (
        .clk          (clk),
        .reset        (rstN),
        .bias_wr_en   (biasWrEn),
        .bias_wr_index(biasWrIndex),
        .bias_wr_data (biasWrData),
        .cfg_mode     (cfgMode),
        .cfg_shift    (cfgShift),
        .in_valid     (inValid),
        .in_ready     (inReady),
        .in_data      (inData),
        .out_valid    (outValid),
        .out_ready    (outReady),
        .out_data     (outData),
        .busy         (busy),
        .beat_count   (beatCount)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [OW-1:0] modelLane(input int inVal, input int biasVal,
                                                input logic [1:0] mode, input int shift);
        longint s, a, r;
        s = longint'(inVal) + longint'(biasVal);
        if (s > MAX_ACC) s = MAX_ACC;
        if (s < MIN_ACC) s = MIN_ACC;
        a = s;
        if (mode == 2'd1 && s < 0) a = 0;
        else if (mode == 2'd2 && s < 0) a = s >>> LS;
        if (shift > 0) r = (a + (longint'(1) << (shift - 1))) >>> shift;
        else r = a;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return r[OW-1:0];
    endfunction

    function automatic logic [N*OW-1:0] expectVec(input logic [N*IW-1:0] d, input logic [1:0] mode,
                                                  input logic [4:0] shift);
        logic [N*OW-1:0] v;
        for (int i = 0; i < N; i++) begin
            v[i*OW +: OW] = modelLane($signed(d[i*IW +: IW]), modelBias[i], mode, int'(shift));
        end
        return v;
    endfunction

    function automatic logic [N*IW-1:0] packIn(input int l0, input int l1, input int l2, input int l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic tick(output bit accepted);
        entry_t e;
        #1;
        cycleCount++;
        inReadySample = inReady;
        checkOutput("in_ready", inReady, (sbQ.size() < 2) || outReady);
        accepted = inValid && inReady;
        if (sbQ.size() == 0) begin
            if (outValid) checkOutput("out_valid_spurious", outValid, 1'b0);
        end else if (outValid) begin
            checkOutput("out_data", outData, sbQ[0].data);
            if (outReady) begin
                if (latencyCheck) checkOutput("latency", cycleCount - sbQ[0].cyc, 2);
                void'(sbQ.pop_front());
                beatModel++;
            end
        end
        if (accepted) begin
            e.data = expectVec(inData, cfgMode, cfgShift);
            e.cyc  = cycleCount;
            sbQ.push_back(e);
        end
        if (biasWrEn) modelBias[biasWrIndex] = $signed(biasWrData);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [N*IW-1:0] d);
        bit acc;
        acc = 1'b0;
        inValid = 1'b1;
        inData  = d;
        for (int n = 0; n < 50 && !acc; n++) tick(acc);
        checkOutput("accept_timeout", acc, 1'b1);
        inValid = 1'b0;
    endtask

    task automatic writeBias(input int idx, input logic [IW-1:0] val);
        bit acc;
        biasWrEn    = 1'b1;
        biasWrIndex = idx[IDXW-1:0];
        biasWrData  = val;
        tick(acc);
        biasWrEn = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        int n;
        n = 0;
        outReady = 1'b1;
        while (sbQ.size() > 0 && n < 50) begin
            tick(acc);
            n++;
        end
        checkOutput("drain_empty", sbQ.size(), 0);
    endtask

    task automatic clearModel();
        sbQ.delete();
        beatModel = 0;
        for (int i = 0; i < N; i++) modelBias[i] = 0;
    endtask

    task automatic doReset();
        rstN     = 1'b0;
        inValid  = 1'b0;
        biasWrEn = 1'b0;
        outReady = 1'b1;
        clearModel();
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        #1;
        checkOutput("rst_out_valid", outValid, 1'b0);
        checkOutput("rst_out_data", outData, '0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_beat_count", beatCount, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        bit acc;
        bit sawLow;
        int sent;
        bit readyPat[4];
        logic [N*IW-1:0] streamData[8];

        rstN = 1'b0;
        clearModel();

        doReset();
        writeBias(0, 32'd10);
        writeBias(1, -32'sd10);
        writeBias(2, 32'd0);
        writeBias(3, 32'd5);
        cfgMode = 2'd1;
        cfgShift = 5'd0;
        latencyCheck = 1'b1;
        applyStimulus(packIn(-20, 5, -1, 100));
        drain();
        latencyCheck = 1'b0;
        checkOutput("beat_count_1", beatCount, 32'd1);

        doReset();
        cfgMode = 2'd2;
        applyStimulus(packIn(-64, -7, 64, -1));
        drain();

        cfgMode = 2'd0;
        cfgShift = 5'd4;
        applyStimulus(packIn(24, -24, 8, 4000));
        applyStimulus(packIn(-5000, 0, 0, 0));
        drain();

        writeBias(0, 32'h7FFFFFFF);
        cfgShift = 5'd24;
        applyStimulus(packIn(1, 0, 0, 0));
        drain();

        doReset();
        cfgMode = 2'd1;
        cfgShift = 5'd2;
        readyPat = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            streamData[i] = packIn(int'($urandom_range(0, 4000)) - 2000, int'($urandom_range(0, 400)) - 100,
                                   i * 37 - 100, int'($urandom_range(0, 2000)));
        end
        sent = 0;
        sawLow = 1'b0;
        for (int c = 0; c < 200 && (sent < 8 || sbQ.size() > 0); c++) begin
            outReady = readyPat[c % 4];
            inValid  = (sent < 8);
            if (sent < 8) inData = streamData[sent];
            tick(acc);
            if (!inReadySample) sawLow = 1'b1;
            if (acc) sent++;
        end
        inValid = 1'b0;
        drain();
        checkOutput("stream_sent", sent, 8);
        checkOutput("in_ready_dropped", sawLow, 1'b1);
        checkOutput("beat_count_stream", beatCount, 32'd8);
        checkOutput("beat_count_model", beatCount, beatModel);

        cfgMode = 2'd0;
        cfgShift = 5'd0;
        biasWrEn = 1'b1;
        biasWrIndex = 2'd2;
        biasWrData = 32'd20;
        inValid = 1'b1;
        inData = packIn(1, 2, 50, 3);
        tick(acc);
        biasWrEn = 1'b0;
        inValid = 1'b0;
        checkOutput("bias_same_cycle_accept", acc, 1'b1);
        applyStimulus(packIn(1, 2, 50, 3));
        drain();

        outReady = 1'b0;
        applyStimulus(packIn(7, 8, 9, 10));
        applyStimulus(packIn(11, 12, 13, 14));
        checkOutput("inflight_count", sbQ.size(), 2);
        rstN = 1'b0;
        #1;
        checkOutput("midrst_out_valid", outValid, 1'b0);
        checkOutput("midrst_busy", busy, 1'b0);
        checkOutput("midrst_beat_count", beatCount, 32'd0);
        clearModel();
        @(negedge clk);
        rstN = 1'b1;
        outReady = 1'b1;
        @(negedge clk);
        applyStimulus(packIn(5, 5, 5, 5));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
